amber128_mem_arbiter: RTL and testbench
=======================================

Name: amber128_mem_arbiter

Overview:
Shares one 128-bit memory port between the amber128 instruction-fetch path (bundle fetch) and the data path (LD128/ST128).
- Arbitrates the two requesters and latches the request at grant.
- Checks alignment and the address window before any memory access; faulting requests never reach memory.
- Drives a single outstanding memory transaction with a timeout and returns one-cycle response pulses.
- Sits between amber128_core and the unified SRAM/bus adapter.

Parameters:
XLEN, 128, data width of the memory port and of both requesters.
AW, 64, byte-address width.
MEM_BYTES, 64'h0001_0000, size of the legal window; a legal access satisfies addr + 16 <= MEM_BYTES.
TIMEOUT_CYCLES, 255, maximum number of cycles to wait for m_ack_i after m_req_o rises.
TO_W, 8, width of the timeout counter; requires TIMEOUT_CYCLES < 2**TO_W.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clk_en_i  in  1  global clock enable; when low, all state freezes
i_req_i  in  1  fetch request; held until i_valid_o
i_addr_i  in  AW  fetch bundle byte address
i_valid_o  out  1  fetch response pulse
i_data_o  out  XLEN  fetched bundle; valid while i_valid_o is high
i_fault_o  out  1  fetch fault, qualified by i_valid_o
d_req_i  in  1  data request; held until d_ready_o
d_we_i  in  1  1 = store, 0 = load
d_addr_i  in  AW  data byte address
d_wdata_i  in  XLEN  store data
d_ready_o  out  1  data response pulse
d_rdata_o  out  XLEN  load data; valid while d_ready_o is high
d_trap_o  out  1  data fault, qualified by d_ready_o
m_req_o  out  1  memory request; held until m_ack_i or timeout
m_we_o  out  1  memory write enable
m_addr_o  out  AW  memory address
m_wdata_o  out  XLEN  memory write data
m_ack_i  in  1  memory completion, single cycle
m_rdata_i  in  XLEN  read data, valid with m_ack_i
m_err_i  in  1  memory error, valid with m_ack_i

Behaviour:
- Reset is asynchronous, active-low (rst_ni); clock is clk_i. All outputs reset to 0. State resets to IDLE, last_grant to FETCH, timeout counter to 0.
- Reset mid-transaction drops m_req_o immediately. Any late m_ack_i arriving afterwards is ignored.
- When clk_en_i is low, nothing advances. Outputs hold their registered values; response pulses are not repeated.
- FSM states:
  - IDLE: samples requests.
  - BUSY: one transaction outstanding.
  - RESP: drives the response pulse for exactly one cycle, then returns to IDLE.
  - Requests are ignored in BUSY and RESP. This prevents re-granting a request that is still held high during its response cycle.
- Arbitration in IDLE:
  - Only one requester pending: it wins.
  - Both pending: the requester that is not last_grant wins (round-robin), so data and fetch alternate under contention.
  - last_grant updates on every grant, including faulting grants.
- Fault check at grant, on the selected address:
  - Misaligned: addr[3:0] != 0.
  - Out of window: addr + 16 > MEM_BYTES. Compute the sum in AW+1 bits so wrap-around faults.
  - A faulting request goes IDLE -> RESP directly with fault = 1, and m_req_o never asserts. Fetch reports i_fault_o; data reports d_trap_o. Read data is 0.
- Legal grant: the selected addr, we and wdata are latched into m_*_o registers, and m_req_o = 1 from the next cycle. Fetch always uses m_we_o = 0.
- In BUSY:
  - Timeout counter increments each enabled cycle.
  - On m_ack_i: the arbiter latches m_rdata_i and m_err_i, drops m_req_o, and goes to RESP. Fault = m_err_i.
  - If the counter reaches TIMEOUT_CYCLES with no ack: m_req_o drops, go to RESP with fault = 1 and data 0.
  - m_ack_i and timeout in the same cycle: the ack wins.
- Latency:
  - Request seen in IDLE at cycle N -> m_req_o at N+1.
  - Ack at cycle M -> response pulse at M+1.
  - Minimum is 2 cycles, with a combinational ack in the same cycle as m_req_o.
  - Fault-path response arrives at N+1.
- Response outputs are registered. i_data_o, d_rdata_o, i_fault_o and d_trap_o are zero outside their pulse cycle.
- m_ack_i outside BUSY is ignored.

Decomposition:
- amber128_pkg gets the following:
  - amber128_arb_state_e {ARB_IDLE, ARB_BUSY, ARB_RESP}.
  - amber128_arb_src_e {ARB_SRC_FETCH, ARB_SRC_DATA}.
  - ARB_LINE_BYTES = 16.
- The window and alignment check is a pure function in the package, shared with the core's capability checks.
- One natural sub-module: amber128_arb_timer, a load/increment/expire counter of width TO_W.

Test Plan:
1. Fetch-only, addr 0x40, memory acks 1 cycle after m_req_o with data 0xA5..A5 -> m_addr_o = 0x40, m_we_o = 0, i_valid_o pulse 3 cycles after i_req_i rises, i_data_o = 0xA5..A5, i_fault_o = 0.
2. Fetch and data requested in the same cycle from reset (last_grant = FETCH) -> data granted first; fetch granted in the IDLE cycle after the data RESP; the next simultaneous pair grants fetch first.
3. Data store, addr 0x1008 (misaligned) -> d_ready_o with d_trap_o = 1 one cycle later; m_req_o stays 0 throughout.
4. Data load, addr 0xFFF0 -> legal (0xFFF0 + 16 = MEM_BYTES); addr 0xFFFF_FFFF_FFFF_FFF0 -> fault via wrap-around, no memory access.
5. Memory never acks -> m_req_o drops after 255 cycles, d_ready_o with d_trap_o = 1; an ack injected 5 cycles later is ignored and no extra pulse appears.
6. rst_ni asserted while in BUSY -> all outputs 0 asynchronously; after release, a held i_req_i is granted cleanly and clk_en_i = 0 for 10 cycles stretches the latency by exactly 10.

Source files
------------

// File: rtl/amber128_pkg.sv
// -----------------------------------------------------------------------------
// amber128_pkg
// Shared types and helpers for the amber128 memory arbiter and the core.
//   amber128_arb_state_e : arbiter FSM states (IDLE / BUSY / RESP)
//   amber128_arb_src_e   : requester identity (instruction fetch / data)
//   ARB_LINE_BYTES       : bytes moved by one 128-bit memory access
//   amber128_line_fault  : alignment + window check for one 16-byte line; also
//                          used by the core's capability checks
// -----------------------------------------------------------------------------
package amber128_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } amber128_arb_state_e;

  typedef enum logic {
    ARB_SRC_FETCH = 1'b0,
    ARB_SRC_DATA  = 1'b1
  } amber128_arb_src_e;

  localparam int unsigned ARB_LINE_BYTES = 16;

  // Addresses handed to the line check are at most this wide.
  localparam int unsigned ARB_ADDR_W = 64;

  // Line size widened by one bit so the end-of-line sum cannot wrap.
  localparam logic [ARB_ADDR_W:0] ARB_LINE_BYTES_EXT = 65'd16;

  // Returns 1 when a 16-byte access at addr is misaligned or leaves the
  // window [0, mem_bytes). The sum is formed one bit wider than the address
  // so that an address near the top of the space faults instead of wrapping.
  function automatic logic amber128_line_fault(
    input logic [ARB_ADDR_W-1:0] addr,
    input logic [ARB_ADDR_W-1:0] mem_bytes
  );
    logic              misaligned_s;
    logic [ARB_ADDR_W:0] line_end_s;
    misaligned_s = (addr[3:0] != 4'd0);
    line_end_s   = {1'b0, addr} + ARB_LINE_BYTES_EXT;
    return misaligned_s || (line_end_s > {1'b0, mem_bytes});
  endfunction

endpackage

// File: rtl/amber128_arb_timer.sv
// -----------------------------------------------------------------------------
// amber128_arb_timer
// Load / increment / expire counter bounding how long the arbiter waits for
// a memory acknowledge.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : clock enable; counter holds when low
//   load_i        : clear the count (takes priority over inc_i)
//   inc_i         : count one waiting cycle
//   expire_o      : high in the waiting cycle whose increment reaches LIMIT
// LIMIT must be below 2**TO_W.
// -----------------------------------------------------------------------------
module amber128_arb_timer #(
  parameter int unsigned TO_W  = 8,
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic load_i,
  input  logic inc_i,
  output logic expire_o
);

  logic [TO_W-1:0] count_r;

  // Wait-cycle counter: cleared on load, advanced on inc, frozen when disabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_r <= {TO_W{1'b0}};
    end else if (en_i) begin
      if (load_i) begin
        count_r <= {TO_W{1'b0}};
      end else if (inc_i) begin
        count_r <= count_r + {{(TO_W-1){1'b0}}, 1'b1};
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Expiry is flagged on the increment that lands on LIMIT, so the waiting
  // side sees exactly LIMIT cycles before giving up.
  assign expire_o = inc_i && ((count_r + {{(TO_W-1){1'b0}}, 1'b1}) == TO_W'(LIMIT));

endmodule

// File: rtl/amber128_mem_arbiter.sv
// -----------------------------------------------------------------------------
// amber128_mem_arbiter
// Shares one 128-bit memory port between the instruction-fetch path and the
// LD128/ST128 data path. One transaction is outstanding at a time; faulting
// requests are answered directly and never reach memory.
// Ports:
//   clk_i, rst_ni, clk_en_i          : clock, async active-low reset, enable
//   i_req_i, i_addr_i                : fetch request (held until i_valid_o)
//   i_valid_o, i_data_o, i_fault_o   : fetch response pulse, bundle, fault
//   d_req_i, d_we_i, d_addr_i,
//   d_wdata_i                        : data request (held until d_ready_o)
//   d_ready_o, d_rdata_o, d_trap_o   : data response pulse, load data, fault
//   m_req_o, m_we_o, m_addr_o,
//   m_wdata_o                        : memory request (held until ack/timeout)
//   m_ack_i, m_rdata_i, m_err_i      : memory completion, read data, error
// -----------------------------------------------------------------------------
module amber128_mem_arbiter
  import amber128_pkg::*;
#(
  parameter int unsigned XLEN           = 128,
  parameter int unsigned AW             = 64,
  parameter logic [63:0] MEM_BYTES      = 64'h0001_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clk_en_i,
  input  logic            i_req_i,
  input  logic [AW-1:0]   i_addr_i,
  output logic            i_valid_o,
  output logic [XLEN-1:0] i_data_o,
  output logic            i_fault_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [AW-1:0]   d_addr_i,
  input  logic [XLEN-1:0] d_wdata_i,
  output logic            d_ready_o,
  output logic [XLEN-1:0] d_rdata_o,
  output logic            d_trap_o,
  output logic            m_req_o,
  output logic            m_we_o,
  output logic [AW-1:0]   m_addr_o,
  output logic [XLEN-1:0] m_wdata_o,
  input  logic            m_ack_i,
  input  logic [XLEN-1:0] m_rdata_i,
  input  logic            m_err_i
);

  amber128_arb_state_e state_r;
  amber128_arb_src_e   last_grant_r;
  amber128_arb_src_e   src_r;

  amber128_arb_src_e   sel_src_s;
  logic [AW-1:0]       sel_addr_s;
  logic                sel_fault_s;
  logic                any_req_s;
  logic                timeout_s;

  logic                resp_fire_s;
  logic                resp_fault_s;
  amber128_arb_src_e   resp_src_s;
  logic [XLEN-1:0]     resp_data_s;
  logic                resp_fetch_s;
  logic                resp_data_src_s;

  // Wait counter: held clear outside BUSY, counts every enabled BUSY cycle.
  amber128_arb_timer #(
    .TO_W  (TO_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (clk_en_i),
    .load_i   (state_r != ARB_BUSY),
    .inc_i    (state_r == ARB_BUSY),
    .expire_o (timeout_s)
  );

  // Requester selection: a lone requester wins, contention goes to whichever
  // side was not granted last; the winner's address is checked immediately.
  always_comb begin
    any_req_s = i_req_i | d_req_i;
    if (i_req_i && d_req_i) begin
      sel_src_s = (last_grant_r == ARB_SRC_FETCH) ? ARB_SRC_DATA : ARB_SRC_FETCH;
    end else if (d_req_i) begin
      sel_src_s = ARB_SRC_DATA;
    end else begin
      sel_src_s = ARB_SRC_FETCH;
    end
    sel_addr_s  = (sel_src_s == ARB_SRC_DATA) ? d_addr_i : i_addr_i;
    sel_fault_s = amber128_line_fault(ARB_ADDR_W'(sel_addr_s), MEM_BYTES);
  end

  // Response to be registered at the next edge: a faulting grant, a memory
  // ack (which beats a simultaneous timeout), or a timeout.
  always_comb begin
    resp_fire_s  = 1'b0;
    resp_fault_s = 1'b0;
    resp_src_s   = src_r;
    resp_data_s  = {XLEN{1'b0}};
    case (state_r)
      ARB_IDLE: begin
        if (any_req_s && sel_fault_s) begin
          resp_fire_s  = 1'b1;
          resp_fault_s = 1'b1;
          resp_src_s   = sel_src_s;
        end else begin
          resp_fire_s  = 1'b0;
        end
      end
      ARB_BUSY: begin
        if (m_ack_i) begin
          resp_fire_s  = 1'b1;
          resp_fault_s = m_err_i;
          resp_data_s  = m_rdata_i;
        end else if (timeout_s) begin
          resp_fire_s  = 1'b1;
          resp_fault_s = 1'b1;
        end else begin
          resp_fire_s  = 1'b0;
        end
      end
      ARB_RESP: begin
        resp_fire_s = 1'b0;
      end
      default: begin
        resp_fire_s = 1'b0;
      end
    endcase
    resp_fetch_s    = resp_fire_s && (resp_src_s == ARB_SRC_FETCH);
    resp_data_src_s = resp_fire_s && (resp_src_s == ARB_SRC_DATA);
  end

  // Arbiter FSM with registered memory-side and response-side outputs.
  // Response registers are rewritten every enabled cycle, which makes each
  // response a single pulse and keeps data/fault at zero outside it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= ARB_IDLE;
      last_grant_r <= ARB_SRC_FETCH;
      src_r        <= ARB_SRC_FETCH;
      m_req_o      <= 1'b0;
      m_we_o       <= 1'b0;
      m_addr_o     <= {AW{1'b0}};
      m_wdata_o    <= {XLEN{1'b0}};
      i_valid_o    <= 1'b0;
      i_fault_o    <= 1'b0;
      i_data_o     <= {XLEN{1'b0}};
      d_ready_o    <= 1'b0;
      d_trap_o     <= 1'b0;
      d_rdata_o    <= {XLEN{1'b0}};
    end else if (clk_en_i) begin
      i_valid_o <= resp_fetch_s;
      i_fault_o <= resp_fetch_s && resp_fault_s;
      i_data_o  <= resp_fetch_s ? resp_data_s : {XLEN{1'b0}};
      d_ready_o <= resp_data_src_s;
      d_trap_o  <= resp_data_src_s && resp_fault_s;
      d_rdata_o <= resp_data_src_s ? resp_data_s : {XLEN{1'b0}};
      case (state_r)
        ARB_IDLE: begin
          if (any_req_s) begin
            last_grant_r <= sel_src_s;
            src_r        <= sel_src_s;
            if (sel_fault_s) begin
              state_r <= ARB_RESP;
            end else begin
              state_r   <= ARB_BUSY;
              m_req_o   <= 1'b1;
              m_addr_o  <= sel_addr_s;
              m_we_o    <= (sel_src_s == ARB_SRC_DATA) && d_we_i;
              m_wdata_o <= (sel_src_s == ARB_SRC_DATA) ? d_wdata_i : {XLEN{1'b0}};
            end
          end
        end
        ARB_BUSY: begin
          if (m_ack_i || timeout_s) begin
            m_req_o <= 1'b0;
            state_r <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          state_r <= ARB_IDLE;
        end
        default: begin
          state_r <= ARB_IDLE;
          m_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amber128_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_amber128_mem_arbiter
// Directed scenarios followed by randomized traffic. A transaction-level
// reference model advances on every enabled clock edge and a single compare
// process checks all DUT outputs against it on every falling edge.
// -----------------------------------------------------------------------------
module tb_amber128_mem_arbiter;

  localparam int          TIMEOUT   = 255;
  localparam logic [63:0] MEM_BYTES = 64'h0001_0000;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         clk_en_i = 1'b1;
  logic         i_req_i = 1'b0;
  logic [63:0]  i_addr_i = 64'd0;
  logic         i_valid_o;
  logic [127:0] i_data_o;
  logic         i_fault_o;
  logic         d_req_i = 1'b0;
  logic         d_we_i = 1'b0;
  logic [63:0]  d_addr_i = 64'd0;
  logic [127:0] d_wdata_i = 128'd0;
  logic         d_ready_o;
  logic [127:0] d_rdata_o;
  logic         d_trap_o;
  logic         m_req_o;
  logic         m_we_o;
  logic [63:0]  m_addr_o;
  logic [127:0] m_wdata_o;
  logic         m_ack_i = 1'b0;
  logic [127:0] m_rdata_i = 128'd0;
  logic         m_err_i = 1'b0;

  amber128_mem_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clk_en_i(clk_en_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i),
    .i_valid_o(i_valid_o), .i_data_o(i_data_o), .i_fault_o(i_fault_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_ready_o(d_ready_o), .d_rdata_o(d_rdata_o), .d_trap_o(d_trap_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_ack_i(m_ack_i), .m_rdata_i(m_rdata_i), .m_err_i(m_err_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit           mdl_open = 1'b0;      // a memory transaction is outstanding
  bit           mdl_hold = 1'b0;      // a response is currently being shown
  bit           mdl_is_data = 1'b0;   // owner of the current transaction
  bit           mdl_last_data = 1'b0; // last grant went to the data side
  int           mdl_wait = 0;         // enabled cycles spent waiting on memory
  logic         e_i_valid = 1'b0, e_i_fault = 1'b0, e_d_ready = 1'b0, e_d_trap = 1'b0;
  logic [127:0] e_i_data = 128'd0, e_d_rdata = 128'd0, e_m_wdata = 128'd0;
  logic         e_m_req = 1'b0, e_m_we = 1'b0;
  logic [63:0]  e_m_addr = 64'd0;

  function automatic bit addr_bad(input logic [63:0] a);
    return ((a % 64'd16) != 64'd0) || (a > MEM_BYTES - 64'd16);
  endfunction

  task automatic model_reset();
    mdl_open = 1'b0; mdl_hold = 1'b0; mdl_is_data = 1'b0; mdl_last_data = 1'b0;
    mdl_wait = 0;
    e_i_valid = 1'b0; e_i_fault = 1'b0; e_i_data = 128'd0;
    e_d_ready = 1'b0; e_d_trap = 1'b0; e_d_rdata = 128'd0;
    e_m_req = 1'b0; e_m_we = 1'b0; e_m_addr = 64'd0; e_m_wdata = 128'd0;
  endtask

  task automatic close_txn(input logic fault, input logic [127:0] data);
    mdl_open = 1'b0;
    mdl_hold = 1'b1;
    e_m_req  = 1'b0;
    if (mdl_is_data) begin
      e_d_ready = 1'b1; e_d_trap = fault; e_d_rdata = data;
    end else begin
      e_i_valid = 1'b1; e_i_fault = fault; e_i_data = data;
    end
  endtask

  task automatic model_step();
    logic [63:0] a;
    bit          pick_d;
    if (mdl_hold) begin
      mdl_hold = 1'b0;
      e_i_valid = 1'b0; e_i_fault = 1'b0; e_i_data = 128'd0;
      e_d_ready = 1'b0; e_d_trap = 1'b0; e_d_rdata = 128'd0;
    end else if (mdl_open) begin
      mdl_wait++;
      if (m_ack_i) close_txn(m_err_i, m_rdata_i);
      else if (mdl_wait >= TIMEOUT) close_txn(1'b1, 128'd0);
    end else if (i_req_i || d_req_i) begin
      pick_d        = d_req_i && (!i_req_i || !mdl_last_data);
      mdl_last_data = pick_d;
      mdl_is_data   = pick_d;
      a             = pick_d ? d_addr_i : i_addr_i;
      if (addr_bad(a)) begin
        close_txn(1'b1, 128'd0);
      end else begin
        mdl_open  = 1'b1;
        mdl_wait  = 0;
        e_m_req   = 1'b1;
        e_m_addr  = a;
        e_m_we    = pick_d && d_we_i;
        e_m_wdata = pick_d ? d_wdata_i : 128'd0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) model_reset();
      else if (clk_en_i) model_step();
    end
  end

  // Single compare process: every output, every falling edge.
  initial begin
    forever begin
      @(negedge clk_i);
      chk("i_valid", i_valid_o, e_i_valid);
      chk("i_fault", i_fault_o, e_i_fault);
      chk("i_data",  i_data_o,  e_i_data);
      chk("d_ready", d_ready_o, e_d_ready);
      chk("d_trap",  d_trap_o,  e_d_trap);
      chk("d_rdata", d_rdata_o, e_d_rdata);
      chk("m_req",   m_req_o,   e_m_req);
      chk("m_we",    m_we_o,    e_m_we);
      chk("m_addr",  m_addr_o,  e_m_addr);
      chk("m_wdata", m_wdata_o, e_m_wdata);
    end
  end

  // ---------------- memory responder ----------------
  int           mreq_age = -1;
  int           ack_delay = 1;
  int           cfg_delay = 1;
  bit           cfg_random = 1'b0;
  bit           cfg_never = 1'b0;
  bit           never_ack = 1'b0;
  bit           inject_ack = 1'b0;
  logic [127:0] cfg_rdata = 128'd0;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic responder();
    m_rdata_i = cfg_random ? rand128() : cfg_rdata;
    m_err_i   = 1'b0;
    if (m_req_o) begin
      if (mreq_age < 0) begin
        mreq_age  = 0;
        ack_delay = cfg_random ? int'($urandom_range(3)) : cfg_delay;
        never_ack = cfg_never || (cfg_random && ($urandom_range(63) == 0));
      end else if (clk_en_i) begin
        mreq_age++;
      end
      m_ack_i = !never_ack && (mreq_age == ack_delay);
      if (m_ack_i && cfg_random) m_err_i = ($urandom_range(5) == 0);
    end else begin
      mreq_age = -1;
      m_ack_i  = inject_ack;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    responder();
  endtask

  task automatic wait_pulse(input bit want_d, input string name, inout int lat);
    int n;
    n = 0;
    while (!(want_d ? d_ready_o : i_valid_o) && n < 400) begin
      tick();
      lat++;
      n++;
    end
    chk(name, want_d ? d_ready_o : i_valid_o, 1'b1);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; i_req_i = 1'b0; d_req_i = 1'b0; clk_en_i = 1'b1;
    tick(); tick();
    rst_ni = 1'b1;
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    case ($urandom_range(9))
      0: a = 64'h0000_0000_0000_FFF0;
      1: a = 64'h0000_0000_0001_0000;
      2: a = 64'hFFFF_FFFF_FFFF_FFF0;
      3: a = (64'($urandom_range(4095)) << 4) | 64'($urandom_range(1, 15));
      default: a = 64'($urandom_range(4095)) << 4;
    endcase
    return a;
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int cnt;
    bit i_prev, d_prev;

    // Reset state
    do_reset();
    chk("rst_m_req", m_req_o, 1'b0);
    chk("rst_i_valid", i_valid_o, 1'b0);

    // 1: single fetch, ack one cycle after m_req_o
    cfg_delay = 1; cfg_rdata = {16{8'hA5}};
    i_req_i = 1'b1; i_addr_i = 64'h40; lat = 0;
    tick(); lat++;
    chk("t1_m_req", m_req_o, 1'b1);
    chk("t1_m_addr", m_addr_o, 64'h40);
    chk("t1_m_we", m_we_o, 1'b0);
    wait_pulse(1'b0, "t1_pulse", lat);
    chk("t1_latency", lat, 3);
    chk("t1_data", i_data_o, {16{8'hA5}});
    chk("t1_fault", i_fault_o, 1'b0);
    tick(); i_req_i = 1'b0;
    tick();
    chk("t1_no_regrant", m_req_o, 1'b0);

    // 2: simultaneous requests from reset, round-robin order
    do_reset();
    cfg_delay = 0;
    i_req_i = 1'b1; i_addr_i = 64'h100;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 64'h200; d_wdata_i = rand128();
    tick(); lat = 1;
    chk("t2_data_first", m_addr_o, 64'h200);
    wait_pulse(1'b1, "t2_d_pulse", lat);
    tick(); d_addr_i = 64'h300;           // data side immediately asks again
    tick();
    chk("t2_fetch_second", m_addr_o, 64'h100);
    wait_pulse(1'b0, "t2_i_pulse", lat);
    tick(); i_req_i = 1'b0;
    tick();
    chk("t2_data_third", m_addr_o, 64'h300);
    wait_pulse(1'b1, "t2_d_pulse2", lat);
    tick(); d_req_i = 1'b0;

    // 3: misaligned store faults without touching memory
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 64'h1008; d_wdata_i = rand128();
    tick();
    chk("t3_ready", d_ready_o, 1'b1);
    chk("t3_trap", d_trap_o, 1'b1);
    chk("t3_no_mreq", m_req_o, 1'b0);
    chk("t3_rdata", d_rdata_o, 128'd0);
    tick(); d_req_i = 1'b0;
    tick();

    // 4: last legal line, then wrap-around fault
    cfg_delay = 2;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 64'hFFF0;
    tick(); lat = 1;
    chk("t4_legal_mreq", m_req_o, 1'b1);
    chk("t4_legal_addr", m_addr_o, 64'hFFF0);
    wait_pulse(1'b1, "t4_pulse", lat);
    chk("t4_legal_trap", d_trap_o, 1'b0);
    tick(); d_addr_i = 64'hFFFF_FFFF_FFFF_FFF0;
    tick();
    chk("t4_wrap_ready", d_ready_o, 1'b1);
    chk("t4_wrap_trap", d_trap_o, 1'b1);
    chk("t4_wrap_no_mreq", m_req_o, 1'b0);
    tick(); d_req_i = 1'b0;
    tick();

    // 5: memory never answers, then a stray late ack
    cfg_never = 1'b1;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 64'h80;
    tick();
    cnt = m_req_o ? 1 : 0;
    while (m_req_o && cnt < 400) begin
      tick();
      if (m_req_o) cnt++;
    end
    chk("t5_req_cycles", cnt, TIMEOUT);
    chk("t5_ready", d_ready_o, 1'b1);
    chk("t5_trap", d_trap_o, 1'b1);
    chk("t5_rdata", d_rdata_o, 128'd0);
    tick(); d_req_i = 1'b0;
    tick(); tick(); tick();
    inject_ack = 1'b1;
    tick();
    inject_ack = 1'b0;
    tick();
    chk("t5_late_ack_ready", d_ready_o, 1'b0);
    chk("t5_late_ack_mreq", m_req_o, 1'b0);
    cfg_never = 1'b0;
    tick();

    // 6: asynchronous reset mid-transaction, then clock-enable stretching
    cfg_delay = 3;
    i_req_i = 1'b1; i_addr_i = 64'h500;
    tick(); tick();
    chk("t6_busy", m_req_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_async_mreq", m_req_o, 1'b0);
    chk("t6_async_maddr", m_addr_o, 64'h0);
    chk("t6_async_ivalid", i_valid_o, 1'b0);
    tick(); tick();
    rst_ni = 1'b1; cfg_delay = 1; lat = 0;
    wait_pulse(1'b0, "t6_pulse", lat);
    chk("t6_lat_base", lat, 3);
    tick(); i_req_i = 1'b0;
    tick();
    i_req_i = 1'b1; i_addr_i = 64'h510; lat = 0;
    tick(); lat++;
    clk_en_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(); lat++;
    end
    clk_en_i = 1'b1;
    wait_pulse(1'b0, "t6_pulse_stretched", lat);
    chk("t6_lat_stretched", lat, 13);
    tick(); i_req_i = 1'b0;
    tick();

    // Randomized traffic
    cfg_random = 1'b1;
    i_prev = 1'b0; d_prev = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (i_prev && !i_valid_o) begin
        i_req_i = 1'b0;
      end else if (!i_req_i && ($urandom_range(3) == 0)) begin
        i_req_i = 1'b1; i_addr_i = rand_addr();
      end
      if (d_prev && !d_ready_o) begin
        d_req_i = 1'b0;
      end else if (!d_req_i && ($urandom_range(3) == 0)) begin
        d_req_i = 1'b1; d_addr_i = rand_addr();
        d_we_i = ($urandom_range(1) == 1); d_wdata_i = rand128();
      end
      clk_en_i = ($urandom_range(7) != 0);
      i_prev = i_valid_o;
      d_prev = d_ready_o;
    end
    clk_en_i = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
